// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT/IDCT datapath.
// Holds the intermediate lane width, the lane count, the block-size code
// enum with its decode helper, and the transpose buffer state enum.
package dct_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 32;

  // Block size code: N = 4 << code.
  typedef enum logic [1:0] {
    SZ4  = 2'd0,
    SZ8  = 2'd1,
    SZ16 = 2'd2,
    SZ32 = 2'd3
  } size_e;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Number of rows/columns in a block for a given size code.
  function automatic logic [5:0] n_of_size(input size_e code);
    return 6'd4 << code;
  endfunction

endpackage

// File: rtl/transpose_buffer_if.sv
// Row-in / column-out handshake bundle of the transpose buffer.
// master: upstream scaler + downstream transform side (drives in_valid,
//         in_data, out_ready).
// slave : the transpose buffer (drives in_ready, out_valid, out_data,
//         out_last).
interface transpose_buffer_if
  import dct_pkg::*;
#(
  parameter int WIDTH  = 22,
  parameter int DATA_W = 16
);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*WIDTH-1:0]    in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic                      out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/transpose_buffer_sat_clip.sv
// Combinational signed saturator from WIDTH bits down to DATA_W bits.
// Ports:
//   din     - signed input lane (WIDTH bits)
//   dout    - input clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
//   clipped - high when the clamp changed the value
module sat_clip #(
  parameter int WIDTH  = 22,
  parameter int DATA_W = 16
) (
  input  logic signed [WIDTH-1:0]  din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     clipped
);

  // The value fits when every bit from the result sign bit upward matches.
  logic [WIDTH-DATA_W:0] upper;

  // Range test and clamp.
  always_comb begin
    upper   = din[WIDTH-1:DATA_W-1];
    clipped = !((&upper) || (~|upper));
    if (!clipped) begin
      dout = din[DATA_W-1:0];
    end else if (din[WIDTH-1]) begin
      dout = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      dout = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/transpose_buffer.sv
// Transpose buffer between the first-stage scaler and the second-stage 1-D
// transform. Collects N saturated rows of an NxN block, then emits the block
// column by column. Single bank: filling and draining never overlap.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   size       - block size code (N = 4 << size), sampled on the first row
//   flush      - synchronous abort of the current block
//   bus        - row input / column output handshakes (slave side)
//   sat_pulse  - one-cycle pulse after an accepted row with a clipped lane
module transpose_buffer
  import dct_pkg::*;
#(
  parameter int WIDTH  = 22,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         size,
  input  logic               flush,
  transpose_buffer_if.slave  bus,
  output logic               sat_pulse
);

  state_e                    state;
  logic [4:0]                row_cnt;
  logic [4:0]                col_cnt;
  size_e                     size_q;

  logic [5:0]                n_cur;
  logic [5:0]                n_drain;
  logic                      row_acc;
  logic                      col_acc;
  logic                      row_last;
  logic                      col_last;
  logic [LANES-1:0]          lane_en;
  logic [LANES-1:0]          clip_flag;
  logic signed [DATA_W-1:0]  clipped [LANES];
  logic signed [DATA_W-1:0]  mem [LANES][LANES];
  logic [LANES*DATA_W-1:0]   out_col;

  for (genvar k = 0; k < LANES; k++) begin : g_sat
    sat_clip #(
      .WIDTH  (WIDTH),
      .DATA_W (DATA_W)
    ) u_sat (
      .din     (bus.in_data[k*WIDTH +: WIDTH]),
      .dout    (clipped[k]),
      .clipped (clip_flag[k])
    );
  end

  // Block size, handshake qualification and end-of-row/column decode.
  // The first row of a block uses the live size input since size_q is only
  // loaded by that very accept.
  always_comb begin
    n_drain = n_of_size(size_q);
    if (row_cnt == 5'd0) begin
      n_cur = n_of_size(size_e'(size));
    end else begin
      n_cur = n_drain;
    end
    row_acc  = bus.in_valid && (state == FILL) && !flush;
    col_acc  = bus.out_ready && (state == DRAIN) && !flush;
    row_last = ({1'b0, row_cnt} == (n_cur - 6'd1));
    col_last = ({1'b0, col_cnt} == (n_drain - 6'd1));
    lane_en  = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      lane_en[k] = (6'(k) < n_cur);
    end
  end

  // Control FSM, counters, size capture and saturation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      row_cnt   <= 5'd0;
      col_cnt   <= 5'd0;
      size_q    <= SZ4;
      sat_pulse <= 1'b0;
    end else if (flush) begin
      state     <= FILL;
      row_cnt   <= 5'd0;
      col_cnt   <= 5'd0;
      sat_pulse <= 1'b0;
    end else begin
      sat_pulse <= row_acc && (|(clip_flag & lane_en));
      case (state)
        FILL: begin
          if (row_acc) begin
            if (row_cnt == 5'd0) begin
              size_q <= size_e'(size);
            end
            if (row_last) begin
              row_cnt <= 5'd0;
              state   <= DRAIN;
            end else begin
              row_cnt <= row_cnt + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (col_acc) begin
            if (col_last) begin
              col_cnt <= 5'd0;
              state   <= FILL;
            end else begin
              col_cnt <= col_cnt + 5'd1;
            end
          end
        end
        default: begin
          state   <= FILL;
          row_cnt <= 5'd0;
          col_cnt <= 5'd0;
        end
      endcase
    end
  end

  // Row storage; contents need no reset because nothing reads them until a
  // complete block has been written.
  always_ff @(posedge clk) begin
    if (row_acc) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) begin
          mem[row_cnt][k] <= clipped[k];
        end
      end
    end
  end

  // Column read-out: lane r takes row r of the current column, unused lanes
  // are zero.
  always_comb begin
    out_col = {(LANES*DATA_W){1'b0}};
    for (int r = 0; r < LANES; r++) begin
      if (6'(r) < n_drain) begin
        out_col[r*DATA_W +: DATA_W] = mem[r][col_cnt];
      end else begin
        out_col[r*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_last  = (state == DRAIN) && col_last;
  assign bus.out_data  = out_col;

endmodule

// File: tb/tb_transpose_buffer.sv
// Self-checking bench for transpose_buffer. Rows are driven from tasks; when
// a block is complete the expected columns are pushed to a scoreboard queue
// and popped as the DUT hands columns out.
module tb_transpose_buffer;
  import dct_pkg::*;

  localparam int W  = 22;
  localparam int DW = 16;
  localparam int L  = 32;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] size  = 2'd0;
  logic       flush = 1'b0;
  logic       sat_pulse;

  transpose_buffer_if #(.WIDTH(W), .DATA_W(DW)) bus ();

  transpose_buffer #(.WIDTH(W), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .size      (size),
    .flush     (flush),
    .bus       (bus),
    .sat_pulse (sat_pulse)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int                    row_vals [L];
  logic signed [DW-1:0]  exp_mem  [L][L];
  logic [L*DW-1:0]       exp_q [$];
  logic                  last_q [$];

  function automatic logic signed [DW-1:0] model_sat(input int v);
    logic signed [DW-1:0] res;
    if (v > 32767) res = 16'h7fff;
    else if (v < -32768) res = 16'h8000;
    else res = DW'(v);
    return res;
  endfunction

  // Push the N expected columns of the block held in exp_mem.
  function automatic void push_block(input int n);
    logic [L*DW-1:0] col;
    for (int c = 0; c < n; c++) begin
      col = '0;
      for (int r = 0; r < n; r++) col[r*DW +: DW] = exp_mem[r][c];
      exp_q.push_back(col);
      last_q.push_back(c == n - 1);
    end
  endfunction

  task automatic send_row(input int r);
    logic [L*W-1:0] v;
    int guard;
    int tmp;
    for (int k = 0; k < L; k++) begin
      tmp = row_vals[k];
      v[k*W +: W] = tmp[W-1:0];
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests_run++;
      tests_failed++;
      $display("FAIL row_accept_timeout: row %0d never accepted, in_ready=%b required 1", r, bus.in_ready);
    end else begin
      @(posedge clk);
      for (int k = 0; k < L; k++) exp_mem[r][k] = model_sat(row_vals[k]);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input int n, input int mult, input int off,
                            input logic [1:0] code0, input logic [1:0] code_rest);
    for (int r = 0; r < n; r++) begin
      size = (r == 0) ? code0 : code_rest;
      for (int k = 0; k < L; k++) row_vals[k] = r * mult + k + off;
      send_row(r);
    end
    push_block(n);
  endtask

  task automatic drain_cols(input int max_cols, input bit rnd, output int accepted);
    logic [L*DW-1:0] held;
    logic [L*DW-1:0] exp_col;
    logic            exp_last;
    bit              stalled;
    int              guard;
    accepted = 0;
    stalled  = 1'b0;
    guard    = 0;
    while (accepted < max_cols && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = 1'b1;
      if (bus.out_valid === 1'b1) begin
        if (stalled) begin
          tests_run++;
          if (bus.out_data !== held) begin
            tests_failed++;
            $display("FAIL stall_stable: out_data %h required %h", bus.out_data, held);
          end
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL extra_column: column %h with empty scoreboard", bus.out_data);
          end else begin
            exp_col  = exp_q.pop_front();
            exp_last = last_q.pop_front();
            tests_run++;
            if (bus.out_data !== exp_col) begin
              tests_failed++;
              $display("FAIL column_%0d: got %h required %h", accepted, bus.out_data, exp_col);
            end
            tests_run++;
            if (bus.out_last !== exp_last) begin
              tests_failed++;
              $display("FAIL out_last_col_%0d: got %b required %b", accepted, bus.out_last, exp_last);
            end
          end
          accepted++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.out_data;
        end
      end
    end
    if (accepted < max_cols) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d columns accepted, required %0d", accepted, max_cols);
    end
  endtask

  task automatic drain_block(input int n, input bit rnd);
    int acc;
    drain_cols(n, rnd, acc);
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL in_ready_after_drain: got %b required 1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL out_valid_after_drain: got %b required 0", bus.out_valid);
    end
  endtask

  task automatic check_drain_entered(input string name);
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: out_valid=%b in_ready=%b required 1/0", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || sat_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_last=%b sat_pulse=%b required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_last, sat_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_4x4();
    send_block(4, 10, 0, 2'd0, 2'd0);
    check_drain_entered("latency_4x4");
    drain_block(4, 1'b0);
  endtask

  task automatic test_32x32_backpressure();
    send_block(32, 32, 0, 2'd3, 2'd3);
    check_drain_entered("latency_32x32");
    drain_block(32, 1'b1);
  endtask

  task automatic test_saturation();
    size = 2'd1;
    for (int k = 0; k < L; k++) row_vals[k] = k;
    row_vals[0] = 40000;
    row_vals[1] = -40000;
    row_vals[2] = 32767;
    send_row(0);
    @(negedge clk);
    tests_run++;
    if (sat_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_pulse_high: got %b required 1", sat_pulse);
    end
    @(negedge clk);
    tests_run++;
    if (sat_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_pulse_width: got %b required 0", sat_pulse);
    end
    for (int r = 1; r < 8; r++) begin
      for (int k = 0; k < L; k++) row_vals[k] = r * 100 - k;
      send_row(r);
      if (r == 1) begin
        @(negedge clk);
        tests_run++;
        if (sat_pulse !== 1'b0) begin
          tests_failed++;
          $display("FAIL sat_pulse_in_range: got %b required 0", sat_pulse);
        end
      end
    end
    push_block(8);
    drain_block(8, 1'b0);
  endtask

  task automatic test_size_change();
    send_block(8, 5, 0, 2'd1, 2'd3);
    check_drain_entered("size_change_drain");
    drain_block(8, 1'b0);
  endtask

  task automatic test_flush();
    int acc;
    send_block(16, 3, -20, 2'd2, 2'd2);
    drain_cols(6, 1'b0, acc);
    @(negedge clk);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_state: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = {L{22'd100000}};
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    tests_run++;
    if (sat_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_row_pulse: sat_pulse=%b required 0", sat_pulse);
    end
    exp_q.delete();
    last_q.delete();
    send_block(16, 11, 5, 2'd2, 2'd2);
    check_drain_entered("flush_next_block");
    drain_block(16, 1'b0);
  endtask

  task automatic test_async_reset();
    send_block(8, 4, 1, 2'd1, 2'd1);
    check_drain_entered("pre_reset_drain");
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_drain: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_q.delete();
    size = 2'd1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < L; k++) row_vals[k] = 1000 + r;
      send_row(r);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_fill: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_block(8, 9, -3, 2'd1, 2'd1);
    check_drain_entered("post_reset_drain");
    drain_block(8, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_4x4();
    test_32x32_backpressure();
    test_saturation();
    test_size_change();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/transpose_buffer.md
Name: transpose_buffer

Overview:
- Sits between the first-stage scaler output and the second-stage 1-D transform of the 2-D DCT/IDCT datapath.
- Accepts one scaled row per handshake, up to 32 lanes of WIDTH bits, and saturates each lane to DATA_W bits.
- Stores rows until a full NxN block is held, then emits the block column by column to the second stage.
- This is the consumer end of the first-stage scaler interface.

Parameters:
- WIDTH, 22, signed input lane width, matching the first-stage scaler output.
- DATA_W, 16, signed stored and output lane width (HEVC intermediate clip).
- LANES, 32, maximum transform size and lane count; fixed, not a configurable range.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- size  in  2  block size code; N = 4<<size (0:4, 1:8, 2:16, 3:32).
- flush  in  1  synchronous abort; drops the current block.
- in_valid  in  1  input row valid.
- in_ready  out  1  buffer can accept a row.
- in_data  in  LANES*WIDTH  row lanes; lane k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  output column valid.
- out_ready  in  1  downstream accepts the column.
- out_data  out  LANES*DATA_W  column lanes; lane r at bits [r*DATA_W +: DATA_W].
- out_last  out  1  high with the final column (c = N-1) of a block.
- sat_pulse  out  1  one-cycle pulse, registered; high the cycle after any accepted row had at least one clipped lane.

Behaviour:
- Reset (rst_n low, asynchronous): state FILL, row_cnt = 0, col_cnt = 0, size_q = 0, sat_pulse = 0, out_valid = 0, out_last = 0, in_ready = 1. Storage contents are don't-care.
- FSM has two states, FILL and DRAIN. in_ready = (state == FILL). out_valid = (state == DRAIN). Both are decoded from registered state.
- FILL:
  - Row accept = in_valid && in_ready. The accepted row is written to mem[row_cnt][k] for k < N.
  - Each stored lane is sat(in lane k). sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Lanes k >= N are ignored.
  - size is sampled into size_q on the accept with row_cnt == 0. Changes to size during the rest of the block are ignored.
  - After the accept with row_cnt == N-1: row_cnt <= 0 and state <= DRAIN. out_valid rises on the next cycle.
- DRAIN:
  - out_data lane r = mem[r][col_cnt] for r < N. Lanes r >= N are driven 0.
  - out_data is combinational from storage and col_cnt, and is stable while out_valid && !out_ready.
  - Column accept = out_valid && out_ready, which increments col_cnt.
  - out_last = (col_cnt == N-1).
  - On the accept with out_last high: col_cnt <= 0 and state <= FILL, so in_ready rises on the next cycle.
- Latency: from the last row accepted at cycle t, column 0 is valid at t+1. A full block occupies 2N handshake cycles minimum. There is no fill/drain overlap (single bank).
- Backpressure: out_ready may stall arbitrarily. in_ready stays low throughout DRAIN.
- Arithmetic: input lanes are signed two's complement. Saturation compares against the DATA_W bounds after sign extension. There is no rounding; values pass through unchanged when in range.
- flush:
  - Takes effect at the next clock edge: state <= FILL, row_cnt <= 0, col_cnt <= 0.
  - flush beats any coincident handshake; a row presented with flush is not stored.
  - sat_pulse is not generated for a flushed row.
- Reset mid-operation discards the block immediately. No output is valid until a new block completes.
- size_q persists across blocks until it is re-sampled.

Decomposition:
- Shared package dct_pkg:
  - DATA_W and LANES constants.
  - Size-code enum (SZ4, SZ8, SZ16, SZ32).
  - Function n_of_size(code) returning 4<<code.
  - The FSM state enum (FILL, DRAIN).
- One sub-module, sat_clip: a combinational WIDTH-to-DATA_W signed saturator with a clipped flag output. Instantiate it LANES times via generate.
- Storage is a LANES x LANES register array inside transpose_buffer.

Test Plan:
- 4x4 transpose:
  - Stimulus: size=0; rows r carry lane k = 10*r+k; out_ready held 1.
  - Required: column c lanes are {c, 10+c, 20+c, 30+c}; lanes 4..31 are 0; out_last on c=3; in_ready returns 1 the cycle after the last column accept.
- 32x32 with backpressure:
  - Stimulus: size=3; lane value = r*32+k; out_ready toggles in a random pattern.
  - Required: every column c equals {c, 32+c, ..., 992+c}; out_data is stable during stalls; exactly 32 column accepts per block.
- Saturation:
  - Stimulus: size=1; a row with lane0 = 40000, lane1 = -40000, lane2 = 32767.
  - Required: stored values 32767, -32768, 32767; sat_pulse high for exactly one cycle after that accept.
  - Required: a row with all lanes in range produces no pulse.
- Size change mid-block:
  - Stimulus: size=1 on row 0, then switched to 3 for rows 1-7.
  - Required: block treated as 8x8; DRAIN entered after 8 rows; 8 columns emitted.
- flush mid-DRAIN:
  - Stimulus: 16x16 block; assert flush after column 5 is accepted.
  - Required: next cycle out_valid = 0 and in_ready = 1; the next 16-row block drains correctly starting at column 0.
  - Required: a row presented together with flush is not counted.
- Async reset mid-FILL:
  - Stimulus: drop rst_n after 3 rows of an 8x8 block.
  - Required: out_valid = 0 and in_ready = 1 immediately; a fresh 8-row block afterwards transposes correctly.
